// File: rtl/inst_mem_sync.sv
// inst_mem_sync
//   Clocked instruction memory for the fetch stage. DEPTH x 32-bit words with a
//   program-load write port and a 1-cycle registered fetch. After every reset a
//   clear sweep writes NOP into each word, one per cycle. Fetches are refused
//   during that sweep and in any cycle that carries a load. Misaligned or
//   out-of-range fetches return NOP with inst_fault raised.
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   fetch_req/addr     fetch request and byte address
//   fetch_ready        fetch can be accepted this cycle (combinational)
//   inst_valid/inst    registered fetch result, 1 cycle after accept
//   inst_fault         accepted fetch was misaligned or out of range
//   load_we/idx/data   program-load word write (RUN only)
module inst_mem_sync #(
  parameter int          DEPTH  = 64,
  parameter int          ADDR_W = 32,
  parameter logic [31:0] NOP    = 32'h0000_0000,
  localparam int         IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic              inst_fault,
  input  logic              load_we,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [31:0]       load_data
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx;
  logic               clr_we;
  logic               accept;
  logic               misalign;
  logic               in_range;
  logic [31:0]        mem [DEPTH];

  // Every bit above the word-index field must be zero, so high addresses never
  // alias back into the array.
  assign misalign = |fetch_addr[1:0];
  assign in_range = (fetch_addr >> (IDX_W + 2)) == '0;
  assign accept   = fetch_req & fetch_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    fetch_ready = 1'b0;
    clr_we      = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx == IDX_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN:     fetch_ready = ~load_we;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) clr_idx <= '0;
    else if (clr_we) clr_idx <= clr_idx + IDX_W'(1);
  end

  // Storage has no reset; the sweep clears it. Writes are suppressed while
  // reset is held so a load in the reset cycle cannot slip in.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we)                          mem[clr_idx]  <= NOP;
      else if (load_we && state_q == RUN)  mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst       <= NOP;
      inst_fault <= 1'b0;
    end else if (accept) begin
      inst_valid <= 1'b1;
      if (misalign || !in_range) begin
        inst       <= NOP;
        inst_fault <= 1'b1;
      end else begin
        inst       <= mem[fetch_addr[IDX_W+1:2]];
        inst_fault <= 1'b0;
      end
    end else begin
      // inst deliberately holds its last value on idle cycles
      inst_valid <= 1'b0;
      inst_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_mem_sync.sv
module tb_inst_mem_sync;

  localparam int DEPTH = 64;
  localparam int IDX_W = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_fault;
  logic        load_we;
  logic [IDX_W-1:0] load_idx;
  logic [31:0] load_data;

  int vectors = 0;
  int miscompares = 0;

  inst_mem_sync #(.DEPTH(DEPTH), .ADDR_W(32), .NOP(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .inst_valid(inst_valid), .inst(inst), .inst_fault(inst_fault),
    .load_we(load_we), .load_idx(load_idx), .load_data(load_data)
  );

  always #5 clk = ~clk;

  // outputs are sampled 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0;
    load_we = 1'b0; load_idx = '0; load_data = '0;
    tick(); tick();
    vectors++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b inst=%h fault=%b, want 0/00000000/0", inst_valid, inst, inst_fault);
    end
    rst_n = 1'b1;
    #1;
    cnt = 0;
    while (fetch_ready !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    vectors++;
    if (cnt != DEPTH) begin
      miscompares++;
      $display("FAIL reset_clear_len: ready low for %0d cycles, want %0d", cnt, DEPTH);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst !== 32'h0 || inst_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL first_fetch: valid=%b inst=%h fault=%b, want 1/00000000/0", inst_valid, inst, inst_fault);
    end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words = '{32'h00000820, 32'h8C220000, 32'h8C230004};
    for (int i = 0; i < 3; i++) begin
      load_we = 1'b1; load_idx = IDX_W'(i); load_data = words[i];
      tick();
    end
    load_we = 1'b0;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'(i * 4);
      tick();
      vectors++;
      if (inst_valid !== 1'b1 || inst !== words[i] || inst_fault !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_word%0d: valid=%b inst=%h fault=%b, want 1/%h/0", i, inst_valid, inst, inst_fault, words[i]);
      end
    end
    fetch_req = 1'b0;
    tick();
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: valid=%b, want 0", inst_valid);
    end
  endtask

  task automatic test_fault();
    logic [31:0] addrs [6];
    logic [31:0] exp_i [6];
    logic        exp_f [6];
    addrs = '{32'h000000FC, 32'h00000006, 32'h00000100, 32'h00000004, 32'h00000003, 32'h80000000};
    exp_i = '{32'hDEADBEEF, 32'h0,        32'h0,        32'h8C220000, 32'h0,        32'h0};
    exp_f = '{1'b0,         1'b1,         1'b1,         1'b0,         1'b1,         1'b1};
    load_we = 1'b1; load_idx = IDX_W'(63); load_data = 32'hDEADBEEF;
    tick();
    load_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fetch_req = 1'b1; fetch_addr = addrs[i];
      tick();
      vectors++;
      if (inst_valid !== 1'b1 || inst !== exp_i[i] || inst_fault !== exp_f[i]) begin
        miscompares++;
        $display("FAIL fault_addr_%h: valid=%b inst=%h fault=%b, want 1/%h/%b", addrs[i], inst_valid, inst, inst_fault, exp_i[i], exp_f[i]);
      end
    end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_load_block();
    load_we = 1'b1; load_idx = IDX_W'(5); load_data = 32'h10430001;
    fetch_req = 1'b1; fetch_addr = 32'h14;
    #1;
    vectors++;
    if (fetch_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_block_ready: fetch_ready=%b, want 0", fetch_ready);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL load_block_valid: valid=%b, want 0", inst_valid);
    end
    load_we = 1'b0;
    #1;
    vectors++;
    if (fetch_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_release_ready: fetch_ready=%b, want 1", fetch_ready);
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b1 || inst !== 32'h10430001 || inst_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL read_after_load: valid=%b inst=%h fault=%b, want 1/10430001/0", inst_valid, inst, inst_fault);
    end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_idle();
    fetch_req = 1'b1; fetch_addr = 32'h4;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (inst_valid !== 1'b0 || inst !== 32'h8C220000 || inst_fault !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold%0d: valid=%b inst=%h fault=%b, want 0/8C220000/0", i, inst_valid, inst, inst_fault);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] addrs [4];
    int cnt;
    addrs = '{32'h0, 32'h14, 32'hFC, 32'h8};
    // in-flight fetch coinciding with reset is dropped
    fetch_req = 1'b1; fetch_addr = 32'h0; rst_n = 1'b0;
    tick();
    vectors++;
    if (inst_valid !== 1'b0 || inst !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_drop: valid=%b inst=%h, want 0/00000000", inst_valid, inst);
    end
    fetch_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1; fetch_req = 1'b1;
    #1;
    cnt = 0;
    while (fetch_ready !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    vectors++;
    if (cnt != DEPTH) begin
      miscompares++;
      $display("FAIL reclear_len: ready low for %0d cycles, want %0d", cnt, DEPTH);
    end
    for (int i = 0; i < 4; i++) begin
      fetch_addr = addrs[i];
      tick();
      vectors++;
      if (inst_valid !== 1'b1 || inst !== 32'h0 || inst_fault !== 1'b0) begin
        miscompares++;
        $display("FAIL cleared_%h: valid=%b inst=%h fault=%b, want 1/00000000/0", addrs[i], inst_valid, inst, inst_fault);
      end
    end
    fetch_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fault();
    test_load_block();
    test_idle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
